// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream instruction loader feeding CPU instruction RAM (optional timeout: INST_LOADER_TIMEOUT_EN)
module inst_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        debug,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [31:0] inst_ram_write_address,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        xfer;
    logic        timeout;
    logic        start_ok;
    logic [7:0]  count_hi;
    logic [15:0] hdr_count;
    logic [15:0] remaining;
    logic [31:0] addr;
    logic [23:0] shift;
    logic [1:0]  byte_cnt;
    logic [31:0] wdata_q;
    logic [31:0] waddr_q;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_count = {count_hi, byte_data};
    assign start_ok  = start & ((state == IDLE) | (state == DONE) | (state == ERROR));

    assign inst_ram_write_data    = wdata_q;
    assign inst_ram_write_address = waddr_q;

    // State register; reset drops straight to IDLE so all state-decoded outputs go low at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-decoded control outputs
    always_comb begin
        state_next            = state;
        byte_ready            = 1'b0;
        debug                 = 1'b0;
        inst_ram_write_enable = 1'b0;
        cpu_reset_n           = 1'b0;
        done                  = 1'b0;
        error                 = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                debug      = 1'b1;
                if (xfer)         state_next = HDR_LO;
                else if (timeout) state_next = ERROR;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                debug      = 1'b1;
                if (xfer) begin
                    if (hdr_count == 16'd0)                 state_next = DONE;
                    else if ({16'd0, hdr_count} > MAX_WORDS) state_next = ERROR;
                    else                                    state_next = DATA;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                debug      = 1'b1;
                if (xfer) begin
                    if (byte_cnt == 2'd3) state_next = WRITE;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            WRITE: begin
                debug                 = 1'b1;
                inst_ram_write_enable = 1'b1;
                state_next            = (remaining == 16'd1) ? DONE : DATA;
            end
            DONE: begin
                cpu_reset_n = 1'b1;
                done        = 1'b1;
                if (start) state_next = HDR_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = HDR_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header latch, word assembly and address/count bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_hi  <= 8'd0;
            remaining <= 16'd0;
            addr      <= 32'd0;
            shift     <= 24'd0;
            byte_cnt  <= 2'd0;
            wdata_q   <= 32'd0;
            waddr_q   <= 32'd0;
        end else begin
            if (start_ok) begin
                addr     <= BASE_ADDR;
                byte_cnt <= 2'd0;
            end
            case (state)
                HDR_HI: if (xfer) count_hi <= byte_data;
                HDR_LO: if (xfer) begin
                    remaining <= hdr_count;
                    byte_cnt  <= 2'd0;
                end
                DATA: if (xfer) begin
                    shift    <= {shift[15:0], byte_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    // The RAM-facing registers only move here, so they hold steady outside WRITE
                    if (byte_cnt == 2'd3) begin
                        wdata_q <= {shift, byte_data};
                        waddr_q <= addr;
                    end
                end
                WRITE: begin
                    addr      <= addr + 32'd4;
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef INST_LOADER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        waiting;

    assign waiting = (state == HDR_HI) | (state == HDR_LO) | (state == DATA);
    assign timeout = waiting & (tmo_cnt == (TIMEOUT_CYCLES - 32'd1));

    // Idle-cycle counter: restarts on every accepted byte and on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= 32'd0;
        end else if (xfer || (state_next != state) || !waiting) begin
            tmo_cnt <= 32'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
module tb_inst_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        debug;
    logic        inst_ram_write_enable;
    logic [31:0] inst_ram_write_data;
    logic [31:0] inst_ram_write_address;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    int n_cmp  = 0;
    int n_bad  = 0;
    int ready_in_write = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    inst_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .byte_valid             (byte_valid),
        .byte_data              (byte_data),
        .byte_ready             (byte_ready),
        .debug                  (debug),
        .inst_ram_write_enable  (inst_ram_write_enable),
        .inst_ram_write_data    (inst_ram_write_data),
        .inst_ram_write_address (inst_ram_write_address),
        .cpu_reset_n            (cpu_reset_n),
        .done                   (done),
        .error                  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (inst_ram_write_enable) begin
            q_addr.push_back(inst_ram_write_address);
            q_data.push_back(inst_ram_write_data);
            if (byte_ready) ready_in_write++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int  budget = 200;
        bit  sent   = 1'b0;
        while (!sent && budget > 0) begin
            byte_data  = b;
            byte_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            sent       = byte_valid && byte_ready;
            @(negedge clk);
            budget--;
        end
        byte_valid = 1'b0;
        if (!sent) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit thr);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], thr);
    endtask

    logic [31:0] words[3];
    int n0;

    initial begin
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {26'd0, byte_ready, debug, inst_ram_write_enable, cpu_reset_n, done, error}, 32'd0);
        check("rst_data", inst_ram_write_data, 32'd0);
        check("rst_addr", inst_ram_write_address, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-word load
        do_start();
        check("hdr_ctrl", {29'd0, byte_ready, debug, cpu_reset_n}, 32'b110);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'h3C01_1234, 0);
        check("w0_strobe", {30'd0, inst_ram_write_enable, byte_ready}, 32'b10);
        check("w0_data", inst_ram_write_data, 32'h3C01_1234);
        check("w0_addr", inst_ram_write_address, 32'h0);
        send_word(32'h0000_000D, 0);
        check("w1_strobe", {31'd0, inst_ram_write_enable}, 32'd1);
        check("w1_data", inst_ram_write_data, 32'h0000_000D);
        check("w1_addr", inst_ram_write_address, 32'h4);
        @(negedge clk);
        check("load_done", {27'd0, done, cpu_reset_n, debug, error, inst_ram_write_enable}, 32'b11000);
        check("hold_data", inst_ram_write_data, 32'h0000_000D);
        check("hold_addr", inst_ram_write_address, 32'h4);
        check("n_strobe2", q_addr.size(), 32'd2);

        // Empty image, restarted from DONE
        n0 = q_addr.size();
        do_start();
        check("restart_cpu", {30'd0, cpu_reset_n, done}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("zero_done", {29'd0, done, cpu_reset_n, error}, 32'b110);
        check("zero_nostb", q_addr.size(), n0);

        // Oversize header 1025 words
        do_start();
        send_byte(8'h04, 0); send_byte(8'h01, 0);
        check("over_err", {29'd0, error, cpu_reset_n, debug}, 32'b100);
        check("over_nostb", q_addr.size(), n0);

        // Exactly MAX_WORDS is accepted
        do_start();
        check("err_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        check("max_accept", {29'd0, byte_ready, debug, error}, 32'b110);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Throttled three-word load
        words[0] = 32'h1122_3344; words[1] = 32'hA5A5_0F0F; words[2] = 32'hDEAD_BEEF;
        n0 = q_addr.size();
        do_start();
        send_byte(8'h00, 1); send_byte(8'h03, 1);
        for (int i = 0; i < 3; i++) send_word(words[i], 1);
        @(negedge clk);
        check("thr_done", {31'd0, done}, 32'd1);
        check("thr_count", q_addr.size(), n0 + 3);
        for (int i = 0; i < 3; i++) begin
            if (q_addr.size() > n0 + i) begin
                check("thr_addr", q_addr[n0+i], 32'(i * 4));
                check("thr_data", q_data[n0+i], words[i]);
            end
        end
        check("ready_in_write", ready_in_write, 32'd0);

        // Asynchronous reset mid-word
        n0 = q_addr.size();
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        #2 reset = 1'b0;
        #1;
        check("async_ctrl", {26'd0, byte_ready, debug, inst_ram_write_enable, cpu_reset_n, done, error}, 32'd0);
        check("async_data", inst_ram_write_data, 32'd0);
        check("async_addr", inst_ram_write_address, 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {30'd0, byte_ready, debug}, 32'd0);
        check("rst_nostb", q_addr.size(), n0);
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hCAFE_F00D, 0);
        check("reload_data", inst_ram_write_data, 32'hCAFE_F00D);
        check("reload_addr", inst_ram_write_address, 32'h0);
        @(negedge clk);
        check("reload_done", {30'd0, done, cpu_reset_n}, 32'b11);

        // Stall after header
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        repeat (15) @(negedge clk);
`ifdef INST_LOADER_TIMEOUT_EN
        check("stall15", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("stall16_err", {30'd0, error, cpu_reset_n}, 32'b10);
`else
        repeat (10) @(negedge clk);
        check("stall_wait", {29'd0, byte_ready, debug, error}, 32'b110);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of first instruction word written.
REQ-002 Parameter: MAX_WORDS, default 1024, largest accepted word count.
REQ-003 Parameter: TIMEOUT_CYCLES, default 1000000, idle cycles between accepted bytes before abort.
REQ-004 Port: clk  in  1  sole clock, all state on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  single-cycle request to begin a load.
REQ-007 Port: byte_valid  in  1  byte_data holds a byte this cycle.
REQ-008 Port: byte_data  in  8  incoming stream byte.
REQ-009 Port: byte_ready  out  1  loader accepts a byte this cycle.
REQ-010 Port: debug  out  1  drives CPU debug; selects write address onto instruction RAM port.
REQ-011 Port: inst_ram_write_enable  out  1  one-cycle write strobe per word.
REQ-012 Port: inst_ram_write_data  out  32  assembled instruction word.
REQ-013 Port: inst_ram_write_address  out  32  byte address of current word.
REQ-014 Port: cpu_reset_n  out  1  active-low reset to CPU; high only after a successful load.
REQ-015 Port: done  out  1  level, load completed.
REQ-016 Port: error  out  1  level, load aborted.

Function
REQ-017 States SHALL be IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
REQ-018 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 exactly in HDR_HI, HDR_LO, DATA.
REQ-019 start=1 in IDLE, DONE or ERROR SHALL enter HDR_HI, clear done/error, load address with BASE_ADDR; start in any other state SHALL be ignored.
REQ-020 HDR_HI SHALL latch count[15:8]; HDR_LO SHALL latch count[7:0] (big-endian 16-bit word count).
REQ-021 In HDR_LO on transfer: count=0 -> DONE; count>MAX_WORDS -> ERROR; else -> DATA.
REQ-022 DATA SHALL shift bytes big-endian (first byte -> bits 31:24); fourth byte transfer -> WRITE.
REQ-023 WRITE SHALL last exactly one cycle with inst_ram_write_enable=1, data and address stable; next cycle address += 4 (32-bit wrap), remaining count -= 1; remaining=0 -> DONE else DATA.
REQ-024 debug SHALL be 1 in HDR_HI, HDR_LO, DATA, WRITE; 0 in IDLE, DONE, ERROR.
REQ-025 cpu_reset_n SHALL be 1 only in DONE; CPU held in reset in all other states, including restart from DONE.
REQ-026 done=1 only in DONE; error=1 only in ERROR.
REQ-027 Write strobe latency: one cycle after the fourth byte's transfer edge.
REQ-028 inst_ram_write_data and inst_ram_write_address SHALL hold last value outside WRITE.

Reset
REQ-029 reset low SHALL immediately force IDLE, all outputs 0 (cpu_reset_n=0, byte_ready=0, debug=0, strobe=0, data=0, address=0), counters cleared.
REQ-030 reset asserted mid-load SHALL abandon the partial word with no further write strobe; release returns to IDLE, awaiting start.

Configuration
REQ-031 Macro INST_LOADER_TIMEOUT_EN defined: cycle counter cleared on each transfer and on state entry, counts in HDR_HI/HDR_LO/DATA; reaching TIMEOUT_CYCLES -> ERROR.
REQ-032 Macro undefined: no timeout counter; loader waits indefinitely; ERROR reachable only via REQ-021.

Verification
REQ-033 start, bytes 00 02 | 3C 01 12 34 | 00 00 00 0D -> strobes at addr 0x0 data 0x3C011234 and addr 0x4 data 0x0000000D, then done=1, cpu_reset_n=1, debug=0.
REQ-034 start, header 00 00 -> DONE with zero strobes, cpu_reset_n=1.
REQ-035 MAX_WORDS=1024, header 04 01 -> error=1, cpu_reset_n=0, no strobe.
REQ-036 byte_valid toggled randomly during 3-word load -> words identical to unthrottled run; byte_ready=0 during each WRITE cycle.
REQ-037 reset pulsed after 2 data bytes -> all outputs 0 asynchronously, no strobe; new start loads correctly from BASE_ADDR.
REQ-038 INST_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16, stall after header 00 01 -> error=1 at 16th idle cycle; without macro, remains in DATA.
